rx_addr_filter: RTL and testbench
=================================

# rx_addr_filter

Receive-side address filter for the WimpFi MAC. Consumes the byte stream from the receiver, compares each frame's destination byte against the locally configured station address `src_mac` (driven by the button-configured MAC register), and forwards only frames addressed to this station or to broadcast into a small first-word-fall-through byte FIFO read by the host-side logic. Non-matching frames are discarded without entering the FIFO.

## Interface
- `DEPTH`, 16, FIFO depth in bytes; power of two, 4..256.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `src_mac`  in  8  local station address, sampled at each frame's first byte.
- `rx_byte`  in  8  received byte.
- `rx_valid`  in  1  one-cycle strobe qualifying `rx_byte`.
- `rx_sof`  in  1  marks the destination byte (first byte of frame); meaningful only with `rx_valid`.
- `rx_eof`  in  1  marks the last byte of frame; meaningful only with `rx_valid`.
- `rx_err`  in  1  one-cycle abort strobe from receiver (bad FCS / carrier loss).
- `rd_en`  in  1  pop FIFO head; ignored when `empty`.
- `rd_data`  out  8  FIFO head byte (valid when `!empty`).
- `rd_last`  out  1  head byte is the last byte of its frame.
- `empty`  out  1  FIFO empty.
- `frame_accept`  out  1  one-cycle pulse when an accepted frame's last byte is written.
- `frame_drop`  out  1  one-cycle pulse when a frame is rejected by address.
- `frame_abort`  out  1  one-cycle pulse when an accepted frame is cut short.
- `overflow`  out  1  sticky: a byte was lost to a full FIFO.
- `accept_cnt`  out  8  count of completed accepted frames.

## Operation
- FSM states: IDLE, PASS, DISCARD. Reset → IDLE.
- Byte with `rx_valid & rx_sof` (any state): match if `rx_byte == src_mac` or `rx_byte == 8'h2A` ("*", broadcast). Match → byte written to FIFO, next PASS; else `frame_drop` pulses, next DISCARD.
- `rx_sof` arriving in PASS: `frame_abort` pulses for the old frame, then the new byte is evaluated as above in the same cycle.
- PASS: every `rx_valid` byte written to FIFO. With `rx_eof`: byte written with last flag, `frame_accept` pulses, `accept_cnt` increments, next IDLE.
- DISCARD: bytes ignored; `rx_eof` → IDLE.
- `rx_sof & rx_eof` on one byte: single-byte frame; decided and closed in that cycle, next IDLE.
- `rx_err` in PASS → `frame_abort`, IDLE; in DISCARD → IDLE; in IDLE ignored. `rx_err` coincident with `rx_valid`: the byte is discarded, error wins.
- `rx_valid` without `rx_sof` in IDLE ignored; `rx_eof` in IDLE ignored.
- FIFO entry = {last, byte}, 9 bits. Write while full: byte dropped, `overflow` set (held until reset); FSM state unaffected; a dropped last byte still pulses `frame_accept`.
- Full evaluated before same-cycle read: simultaneous write and read when full drops the write.
- `accept_cnt` wraps 255 → 0.
- Bytes of an aborted frame already in the FIFO stay; host uses `frame_abort` to discard them.

## Timing
- Reset values: state IDLE, FIFO empty (`empty`=1), `rd_data`/`rd_last` don't-care, all pulses 0, `overflow`=0, `accept_cnt`=0.
- `frame_accept`, `frame_drop`, `frame_abort` registered: assert the cycle after the triggering input edge, one cycle wide.
- Byte written on edge with `rx_valid`; `empty` deasserts and `rd_data` shows it the following cycle (1-cycle latency).
- `rd_en` with `!empty` advances head on that edge; next byte visible next cycle.
- Back-to-back `rx_valid` every cycle supported.
- Reset mid-frame: FSM to IDLE, FIFO flushed, counters cleared at that edge.

## Configuration
- `RX_FILTER_PROMISC_EN`: when defined, adds input port `promisc` (1 bit); while high, every frame is treated as a match (destination check bypassed, `frame_drop` never pulses). When undefined, port absent and filtering is always active.

## Test plan
- `src_mac`=0x41, frame 0x41,0x40,0x10,0x55 (eof on 0x55) → 4 bytes read out in order, `rd_last` only on 0x55, `frame_accept` one pulse, `accept_cnt`=1.
- Frame dest 0x42 with `src_mac`=0x41 → `frame_drop` pulse, FIFO stays empty, `accept_cnt` unchanged.
- Frame dest 0x2A → accepted regardless of `src_mac`.
- Accepted frame 0x41,0x40 then `rx_sof` with 0x41 before eof → `frame_abort` pulse, new frame accepted; likewise `rx_err` mid-frame → `frame_abort`, FSM IDLE.
- `DEPTH`=16, 20-byte accepted frame, no reads → first 16 bytes stored, `overflow`=1, `frame_accept` pulses; reset clears `overflow`, `empty`=1.
- 256 accepted single-byte frames → `accept_cnt` returns to 0; with `RX_FILTER_PROMISC_EN` and `promisc`=1, dest 0x42 accepted.

Source files
------------

// File: rtl/rx_addr_filter.sv
`default_nettype none
// ============================================================================
// Module   : rx_addr_filter
// Purpose  : WimpFi receive address filter with a first-word-fall-through
//            byte FIFO. Optional macro: RX_FILTER_PROMISC_EN (adds promisc).
// Revision : 1.0 - initial release
// ============================================================================
module rx_addr_filter #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
`ifdef RX_FILTER_PROMISC_EN
  input  logic       promisc,
`endif
  input  logic [7:0] src_mac,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  input  logic       rx_sof,
  input  logic       rx_eof,
  input  logic       rx_err,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       rd_last,
  output logic       empty,
  output logic       frame_accept,
  output logic       frame_drop,
  output logic       frame_abort,
  output logic       overflow,
  output logic [7:0] accept_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_PTR_ONE = 1;
  localparam logic [7:0]  c_BCAST   = 8'h2A;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PASS    = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_match;
  logic        w_wr;
  logic        w_last;
  logic        w_accept;
  logic        w_drop;
  logic        w_abort;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;

  logic [8:0]  r_mem [DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic        r_frame_accept;
  logic        r_frame_drop;
  logic        r_frame_abort;
  logic        r_overflow;
  logic [7:0]  r_accept_cnt;

`ifdef RX_FILTER_PROMISC_EN
  assign w_match = promisc || (rx_byte == src_mac) || (rx_byte == c_BCAST);
`else
  assign w_match = (rx_byte == src_mac) || (rx_byte == c_BCAST);
`endif

  // rx_err dominates: a byte arriving with the error strobe is never processed.
  always_comb begin
    w_state_nxt = r_state;
    w_wr        = 1'b0;
    w_last      = 1'b0;
    w_accept    = 1'b0;
    w_drop      = 1'b0;
    w_abort     = 1'b0;
    if (rx_err) begin
      w_abort     = (r_state == ST_PASS);
      w_state_nxt = ST_IDLE;
    end else if (rx_valid && rx_sof) begin
      w_abort = (r_state == ST_PASS);
      if (w_match) begin
        w_wr        = 1'b1;
        w_last      = rx_eof;
        w_accept    = rx_eof;
        w_state_nxt = rx_eof ? ST_IDLE : ST_PASS;
      end else begin
        w_drop      = 1'b1;
        w_state_nxt = rx_eof ? ST_IDLE : ST_DISCARD;
      end
    end else if (rx_valid) begin
      case (r_state)
        ST_PASS: begin
          w_wr     = 1'b1;
          w_last   = rx_eof;
          w_accept = rx_eof;
          if (rx_eof) w_state_nxt = ST_IDLE;
        end
        ST_DISCARD: begin
          if (rx_eof) w_state_nxt = ST_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Full is judged before any same-cycle pop, so a write into a full FIFO is lost.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push  = w_wr && !w_full;
  assign w_pop   = rd_en && !w_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= {w_last, rx_byte};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_frame_accept <= 1'b0;
      r_frame_drop   <= 1'b0;
      r_frame_abort  <= 1'b0;
      r_overflow     <= 1'b0;
      r_accept_cnt   <= 8'd0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + c_PTR_ONE;
      if (w_wr && w_full) r_overflow <= 1'b1;
      if (w_accept) r_accept_cnt <= r_accept_cnt + 8'd1;
      r_frame_accept <= w_accept;
      r_frame_drop   <= w_drop;
      r_frame_abort  <= w_abort;
    end
  end

  assign rd_data      = r_mem[r_rptr[AW-1:0]][7:0];
  assign rd_last      = r_mem[r_rptr[AW-1:0]][8];
  assign empty        = w_empty;
  assign frame_accept = r_frame_accept;
  assign frame_drop   = r_frame_drop;
  assign frame_abort  = r_frame_abort;
  assign overflow     = r_overflow;
  assign accept_cnt   = r_accept_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rx_addr_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_addr_filter
// Purpose  : Self-checking bench for rx_addr_filter against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_addr_filter;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] src_mac;
  logic [7:0] rx_byte;
  logic       rx_valid, rx_sof, rx_eof, rx_err, rd_en;
  logic [7:0] rd_data;
  logic       rd_last, empty, frame_accept, frame_drop, frame_abort, overflow;
  logic [7:0] accept_cnt;
`ifdef RX_FILTER_PROMISC_EN
  logic       promisc = 1'b0;
`endif

  rx_addr_filter #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
`ifdef RX_FILTER_PROMISC_EN
    .promisc      (promisc),
`endif
    .src_mac      (src_mac),
    .rx_byte      (rx_byte),
    .rx_valid     (rx_valid),
    .rx_sof       (rx_sof),
    .rx_eof       (rx_eof),
    .rx_err       (rx_err),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_last      (rd_last),
    .empty        (empty),
    .frame_accept (frame_accept),
    .frame_drop   (frame_drop),
    .frame_abort  (frame_abort),
    .overflow     (overflow),
    .accept_cnt   (accept_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: FIFO as a queue, frame status 0 = none, 1 = kept, 2 = rejected.
  logic [8:0] m_q[$];
  int         m_frame;
  bit         m_acc, m_drop, m_abort, m_ovf;
  int         m_cnt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit hit, wr, last, full;
    wr = 0; last = 0;
    if (reset) begin
      m_q.delete(); m_frame = 0; m_acc = 0; m_drop = 0; m_abort = 0; m_ovf = 0; m_cnt = 0;
      return;
    end
    m_acc = 0; m_drop = 0; m_abort = 0;
    full = (m_q.size() == DEPTH);
    hit  = (rx_byte == src_mac) || (rx_byte == 8'h2A);
`ifdef RX_FILTER_PROMISC_EN
    hit  = hit || promisc;
`endif
    if (rx_err) begin
      if (m_frame == 1) m_abort = 1;
      m_frame = 0;
    end else if (rx_valid && rx_sof) begin
      if (m_frame == 1) m_abort = 1;
      if (hit) begin
        wr = 1; last = rx_eof;
        m_frame = rx_eof ? 0 : 1;
      end else begin
        m_drop = 1;
        m_frame = rx_eof ? 0 : 2;
      end
    end else if (rx_valid && m_frame == 1) begin
      wr = 1; last = rx_eof;
      if (rx_eof) m_frame = 0;
    end else if (rx_valid && m_frame == 2 && rx_eof) begin
      m_frame = 0;
    end
    if (wr && last) begin
      m_acc = 1;
      m_cnt = (m_cnt + 1) % 256;
    end
    if (rd_en && m_q.size() > 0) void'(m_q.pop_front());
    if (wr) begin
      if (full) m_ovf = 1;
      else      m_q.push_back({last, rx_byte});
    end
  endtask

  task automatic step(input logic v, input logic s, input logic e, input logic er,
                      input logic [7:0] b, input logic rd, input logic rs);
    rx_valid = v; rx_sof = s; rx_eof = e; rx_err = er; rx_byte = b; rd_en = rd; reset = rs;
    model_edge();
    @(posedge clk);
    #1;
    check_val("empty", empty, (m_q.size() == 0));
    if (m_q.size() > 0) begin
      check_val("rd_data", rd_data, m_q[0][7:0]);
      check_val("rd_last", rd_last, m_q[0][8]);
    end
    check_val("frame_accept", frame_accept, m_acc);
    check_val("frame_drop", frame_drop, m_drop);
    check_val("frame_abort", frame_abort, m_abort);
    check_val("overflow", overflow, m_ovf);
    check_val("accept_cnt", accept_cnt, m_cnt[7:0]);
  endtask

  task automatic send(input logic [7:0] b, input logic s, input logic e);
    step(1'b1, s, e, 1'b0, b, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic rd);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, rd, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);
  endtask

  initial begin
    logic [7:0] fr [4];
    src_mac = 8'h41;
    rx_valid = 0; rx_sof = 0; rx_eof = 0; rx_err = 0; rx_byte = 0; rd_en = 0; reset = 1;
    m_q.delete(); m_frame = 0; m_acc = 0; m_drop = 0; m_abort = 0; m_ovf = 0; m_cnt = 0;
    step(0, 0, 0, 0, 8'h00, 0, 1'b1);
    step(0, 0, 0, 0, 8'h00, 0, 1'b1);
    check_val("reset_empty", empty, 1'b1);
    check_val("reset_cnt", accept_cnt, 8'd0);

    fr[0] = 8'h41; fr[1] = 8'h40; fr[2] = 8'h10; fr[3] = 8'h55;
    for (int i = 0; i < 4; i++) send(fr[i], i == 0, i == 3);
    for (int i = 0; i < 4; i++) begin
      check_val("order", rd_data, fr[i]);
      idle(1'b1);
    end
    check_val("cnt_one", accept_cnt, 8'd1);

    send(8'h42, 1, 0); send(8'h01, 0, 0); send(8'h02, 0, 1); idle(0);
    send(8'h2A, 1, 0); send(8'h99, 0, 1); drain();

    send(8'h41, 1, 0); send(8'h40, 0, 0); send(8'h41, 1, 0); send(8'h07, 0, 1);
    send(8'h41, 1, 0); send(8'h40, 0, 0);
    step(1, 0, 0, 1'b1, 8'h33, 0, 0);
    send(8'h05, 0, 1); drain();
    send(8'h41, 1, 1); drain();

    for (int i = 0; i < 20; i++) send((i == 0) ? 8'h41 : 8'(i), i == 0, i == 19);
    check_val("ovf_set", overflow, 1'b1);
    step(0, 0, 0, 0, 8'h00, 0, 1'b1);
    check_val("ovf_clr", overflow, 1'b0);
    check_val("ovf_empty", empty, 1'b1);

    for (int i = 0; i < 256; i++) step(1, 1, 1, 0, 8'h2A, 1'b1, 0);
    check_val("cnt_wrap", accept_cnt, 8'd0);
    drain();

`ifdef RX_FILTER_PROMISC_EN
    promisc = 1'b1;
    send(8'h42, 1, 0); send(8'h11, 0, 1); drain();
    promisc = 1'b0;
`endif

    for (int i = 0; i < 4000; i++) begin
      logic [7:0] b;
      int sel;
      if ($urandom_range(0, 199) == 0) src_mac = 8'($urandom);
      sel = $urandom_range(0, 3);
      b = (sel == 0) ? src_mac : (sel == 1) ? 8'h2A : 8'($urandom);
      step($urandom_range(0, 9) < 6,
           $urandom_range(0, 9) < 2,
           $urandom_range(0, 9) < 2,
           $urandom_range(0, 49) == 0,
           b,
           $urandom_range(0, 9) < 4,
           $urandom_range(0, 499) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
